// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Used by the queue, the interface and the top-level fetch unit.
package ifu_pkg;

  localparam int IFU_QDEPTH = 2;
  localparam int IFU_ADDR_W = 32;
  localparam int IFU_DATA_W = 32;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FULL
  } ifu_state_t;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_DATA_W-1:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory-side and decode-side signals of the fetch unit.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface instruction_fetch_unit_if
  import ifu_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W,
  parameter int DATA_W = IFU_DATA_W
);

  logic [ADDR_W-1:0] mem_pc;
  logic [DATA_W-1:0] mem_inst;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;

  modport master (
    output mem_pc,
    input  mem_inst,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst
  );

  modport slave (
    input  mem_pc,
    output mem_inst,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst
  );

endinterface

// File: rtl/ifu_queue.sv
// Two-entry FIFO holding fetched {pc, inst} pairs; slot0 is always the head.
// Flush wins over push and pop in the same cycle.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter type entry_t = ifu_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     push_entry,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     slot0_q, slot0_d;
  entry_t     slot1_q, slot1_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_entry;
          else                 slot1_d = push_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // With one entry the new word becomes head; with two it shifts in behind.
          if (count_q == 2'd1) begin
            slot0_d = push_entry;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC register, BOOT/RUN/FULL control and redirect handling in front of a 2-entry queue.
// Optional IFU_PERF_COUNT_EN adds fetch_count and stall_count outputs.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                DATA_W   = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  instruction_fetch_unit_if.master bus
`ifdef IFU_PERF_COUNT_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [31:0]              stall_count
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  localparam logic [1:0] QFULL = 2'(IFU_QDEPTH);

  ifu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count;
  logic [1:0]        count_nx;
  logic              pop;
  logic              fetch;
  entry_t            push_entry;
  entry_t            head;

  assign pop   = bus.out_valid & bus.out_ready;
  assign fetch = (state_q != BOOT) & enable & ~redirect_valid & ((count < QFULL) | pop);

  always_comb begin
    push_entry.pc   = pc_q;
    push_entry.inst = bus.mem_inst;
    pc_d            = pc_q;
    count_nx        = count + {1'b0, fetch} - {1'b0, pop};
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_nx = 2'd0;
    end else if (fetch) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // FULL tracks the queue occupancy one cycle ahead so it matches count after the edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (count_nx == QFULL) state_d = FULL;
      FULL:    if (count_nx <  QFULL) state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redirect_valid) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifu_queue #(
    .entry_t (entry_t)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fetch),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign bus.mem_pc    = pc_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = head.pc;
  assign bus.out_inst  = head.inst;

`ifdef IFU_PERF_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, fetch};
    stall_count_d = stall_count_q + {31'd0, (state_q == FULL) & ~pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a main instance at RESET_PC 0 and a
// second instance at RESET_PC 0xFFFFFFFE for PC wrap-around.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        enable2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  int          testsRun = 0;
  int          testsFailed = 0;
  exp_t        expQ[$];
  exp_t        expQ2[$];

`ifdef IFU_PERF_COUNT_EN
  logic [31:0] fetchCount, stallCount, fetchCount2, stallCount2;
`endif

  instruction_fetch_unit_if bus ();
  instruction_fetch_unit_if bus2 ();

  // Instruction memory model: word at address k is 0x1000 + k.
  assign bus.mem_inst  = bus.mem_pc + 32'h1000;
  assign bus2.mem_inst = bus2.mem_pc + 32'h1000;

  instruction_fetch_unit #(
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
`ifdef IFU_PERF_COUNT_EN
    ,
    .fetch_count    (fetchCount),
    .stall_count    (stallCount)
`endif
  );

  instruction_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFE)
  ) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable2),
    .redirect_valid (redirect2),
    .redirect_pc    (redirect_pc2),
    .bus            (bus2)
`ifdef IFU_PERF_COUNT_EN
    ,
    .fetch_count    (fetchCount2),
    .stall_count    (stallCount2)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic redir, input logic [31:0] rpc);
    enable         = en;
    bus.out_ready  = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpect(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = pc + 32'h1000;
    expQ.push_back(e);
  endtask

  task automatic pushExpect2(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = pc + 32'h1000;
    expQ2.push_back(e);
  endtask

  initial begin
    // Monitors pop the scoreboards on every accepted output, independent of stimulus.
    fork
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
              testsRun++;
              testsFailed++;
              $display("[TB] FAIL unexpected_output: got pc %h, expected no output", bus.out_pc);
            end else begin
              e = expQ.pop_front();
              checkOutput("head_pc", bus.out_pc, e.pc);
              checkOutput("head_inst", bus.out_inst, e.inst);
            end
          end
        end
      end
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n === 1'b1 && bus2.out_valid === 1'b1 && bus2.out_ready === 1'b1) begin
            if (expQ2.size() == 0) begin
              testsRun++;
              testsFailed++;
              $display("[TB] FAIL wrap_unexpected_output: got pc %h, expected no output", bus2.out_pc);
            end else begin
              e = expQ2.pop_front();
              checkOutput("wrap_head_pc", bus2.out_pc, e.pc);
              checkOutput("wrap_head_inst", bus2.out_inst, e.inst);
            end
          end
        end
      end
    join_none

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    bus2.out_ready = 1'b1;
    enable2        = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_mem_pc", bus.mem_pc, 32'h0);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_out_pc", bus.out_pc, 32'h0);
    checkOutput("reset_out_inst", bus.out_inst, 32'h0);
    checkOutput("wrap_reset_mem_pc", bus2.mem_pc, 32'hFFFF_FFFE);

    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) pushExpect(k);
    pushExpect2(32'hFFFF_FFFE);
    pushExpect2(32'hFFFF_FFFF);
    pushExpect2(32'h0);

    step();
    checkOutput("boot_mem_pc", bus.mem_pc, 32'h0);
    checkOutput("boot_no_output", {31'd0, bus.out_valid}, 32'd0);

    for (int k = 1; k <= 5; k++) begin
      step();
      checkOutput("stream_mem_pc", bus.mem_pc, k);
      if (k == 3) enable2 = 1'b0;
    end
    checkOutput("wrap_mem_pc", bus2.mem_pc, 32'h1);
    checkOutput("wrap_drained", {31'd0, bus2.out_valid}, 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("full_mem_pc", bus.mem_pc, 32'h6);
      checkOutput("full_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("full_head_pc", bus.out_pc, 32'h4);
      checkOutput("full_head_inst", bus.out_inst, 32'h1004);
    end

    pushExpect(32'h4);
    pushExpect(32'h5);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput("drain_mem_pc", bus.mem_pc, 32'h7);
    step();
    checkOutput("drain_mem_pc", bus.mem_pc, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef IFU_PERF_COUNT_EN
    checkOutput("fetch_count", fetchCount, 32'd8);
    checkOutput("stall_count", stallCount, 32'd4);
`endif

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    step();
    checkOutput("redirect_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("redirect_mem_pc", bus.mem_pc, 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("redirect_first_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("redirect_first_pc", bus.out_pc, 32'h40);
    checkOutput("redirect_first_inst", bus.out_inst, 32'h1040);

    for (int k = 'h40; k <= 'h43; k++) pushExpect(k);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput("post_redirect_mem_pc", bus.mem_pc, 32'h42);
    step();
    checkOutput("post_redirect_mem_pc", bus.mem_pc, 32'h43);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("disabled_mem_pc", bus.mem_pc, 32'h43);
      checkOutput("disabled_drained", {31'd0, bus.out_valid}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput("resume_head_pc", bus.out_pc, 32'h43);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("pre_reset_head_pc", bus.out_pc, 32'h44);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("async_reset_mem_pc", bus.mem_pc, 32'h0);
    checkOutput("async_reset_out_pc", bus.out_pc, 32'h0);
    checkOutput("async_reset_out_inst", bus.out_inst, 32'h0);
    checkOutput("sb_main_drained", expQ.size(), 32'd0);
    checkOutput("sb_wrap_drained", expQ2.size(), 32'd0);

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
